// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared channel state encoding and raw fault decode
package sensor_pkg;

  localparam int SENSOR_BITS = 4;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_PEND  = 2'd1,
    ST_FAULT = 2'd2
  } chan_state_t;

  // A channel is in raw error when bit0 is set, or bit1 together with bit2 or bit3
  function automatic logic raw_error(input logic [SENSOR_BITS-1:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

endpackage

// File: rtl/sensor_chan.sv
// rtl/sensor_chan.sv - one sensor channel: raw decode, debounce FSM, sticky fault flag
module sensor_chan
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SENSOR_BITS-1:0] bits,
  input  logic                   clear,
  output logic                   error,
  output logic                   fault_latched,
  output logic                   entering
);

  localparam int              CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE - 1);

  chan_state_t   state;
  logic [CW-1:0] count;
  logic          raw;

  // Decode raw error and flag the edge on which this channel will enter FAULT
  always_comb begin
    raw      = raw_error(bits);
    entering = 1'b0;
    if (raw) begin
      case (state)
        ST_OK:   entering = (DEBOUNCE == 1);
        ST_PEND: entering = (count == LAST);
        default: entering = 1'b0;
      endcase
    end
  end

  // Debounce FSM with registered error output; any raw=0 sample restarts from OK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OK;
      count <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        ST_OK: begin
          if (raw) begin
            if (DEBOUNCE == 1) begin
              state <= ST_FAULT;
              error <= 1'b1;
            end else begin
              state <= ST_PEND;
              count <= CW'(1);
            end
          end else begin
            count <= '0;
          end
        end
        ST_PEND: begin
          if (!raw) begin
            state <= ST_OK;
            count <= '0;
          end else if (count == LAST) begin
            state <= ST_FAULT;
            error <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_FAULT: begin
          if (!raw) begin
            state <= ST_OK;
            count <= '0;
            error <= 1'b0;
          end
        end
        default: begin
          state <= ST_OK;
          count <= '0;
          error <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag: a new fault entry beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_latched <= 1'b0;
    end else if (entering) begin
      fault_latched <= 1'b1;
    end else if (clear) begin
      fault_latched <= 1'b0;
    end
  end

endmodule

// File: rtl/sensor_monitor.sv
// rtl/sensor_monitor.sv - multi-channel sensor fault monitor with saturating event count
module sensor_monitor
  import sensor_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DEBOUNCE  = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SENSOR_BITS*NUM_CH-1:0] sensors,
  input  logic                          clear,
  output logic [NUM_CH-1:0]             error,
  output logic [NUM_CH-1:0]             fault_latched,
  output logic                          any_fault,
  output logic [CNT_WIDTH-1:0]          fault_count
);

  localparam int                   SW      = CNT_WIDTH + 5;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NUM_CH-1:0]    entering;
  logic [4:0]           pop;
  logic [SW-1:0]        sum;
  logic [CNT_WIDTH-1:0] count_next;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    sensor_chan #(.DEBOUNCE(DEBOUNCE)) u_chan (
      .clk           (clk),
      .rst           (rst),
      .bits          (sensors[SENSOR_BITS*k +: SENSOR_BITS]),
      .clear         (clear),
      .error         (error[k]),
      .fault_latched (fault_latched[k]),
      .entering      (entering[k])
    );
  end

  // Count channels entering FAULT this edge and clamp the running total
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + 5'(entering[i]);
    end
    sum        = SW'(fault_count) + SW'(pop);
    count_next = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  // Fault-entry event counter, unaffected by clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_count <= '0;
    end else begin
      fault_count <= count_next;
    end
  end

  assign any_fault = |fault_latched;

endmodule
